// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing controller.
// Lamp codes are ordered {red, amber, green}.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2,
    CLEAR = 2'd3
  } ped_state_t;

  localparam logic [2:0] L_RED       = 3'b100;
  localparam logic [2:0] L_RED_AMBER = 3'b110;
  localparam logic [2:0] L_GREEN     = 3'b001;
  localparam logic [2:0] L_AMBER     = 3'b010;

  function automatic logic lamp_legal(input logic [2:0] code);
    logic ok;
    case (code)
      L_RED, L_RED_AMBER, L_GREEN, L_AMBER: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_btn_sync.sv
// Two-flop synchroniser for the push button followed by a rising-edge detector.
// The pulse lasts one cycle per press, however long the button is held.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the traffic-light FSM lamps.
// Walks only on red alone, holds the traffic FSM on red while crossing, flags bad lamps.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red,
  input  logic amber,
  input  logic green,
  input  logic button,
  output logic hold,
  output logic walk,
  output logic flash,
  output logic dont_walk,
  output logic waiting,
  output logic fault
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

  logic [2:0]       lamps;
  logic             btn_pulse;
  ped_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             req_reg, req_next;
  logic             hold_reg, hold_next;
  logic             walk_reg, walk_next;
  logic             flash_reg, flash_next;
  logic             dont_walk_reg, dont_walk_next;
  logic             waiting_reg, waiting_next;
  logic             fault_reg, fault_next;

  assign lamps = {red, amber, green};

  btn_sync u_btn_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (button),
    .pulse    (btn_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_reg       <= 1'b0;
      hold_reg      <= 1'b0;
      walk_reg      <= 1'b0;
      flash_reg     <= 1'b0;
      dont_walk_reg <= 1'b1;
      waiting_reg   <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_reg       <= req_next;
      hold_reg      <= hold_next;
      walk_reg      <= walk_next;
      flash_reg     <= flash_next;
      dont_walk_reg <= dont_walk_next;
      waiting_reg   <= waiting_next;
      fault_reg     <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    flash_next = 1'b0;
    fault_next = fault_reg | ~lamp_legal(lamps);

    case (state_reg)
      IDLE: begin
        // A pulse arriving on the entry edge is absorbed with the pending request.
        if (req_reg && lamps == L_RED) begin
          state_next = WALK;
          cnt_next   = WALK_LOAD;
          req_next   = 1'b0;
        end else begin
          req_next = req_reg | btn_pulse;
        end
      end
      WALK: begin
        if (lamps != L_RED) begin
          fault_next = 1'b1;
          state_next = CLEAR;
        end else if (cnt_reg == '0) begin
          state_next = FLASH;
          cnt_next   = FLASH_LOAD;
          flash_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      FLASH: begin
        if (lamps != L_RED) begin
          fault_next = 1'b1;
          state_next = CLEAR;
        end else if (cnt_reg == '0) begin
          state_next = CLEAR;
        end else begin
          cnt_next   = cnt_reg - 1'b1;
          flash_next = ~flash_reg;
        end
      end
      CLEAR: begin
        state_next = IDLE;
        req_next   = req_reg | btn_pulse;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    hold_next      = (state_next != IDLE);
    walk_next      = (state_next == WALK);
    dont_walk_next = (state_next == IDLE) || (state_next == CLEAR);
    waiting_next   = req_next;
  end

  assign hold      = hold_reg;
  assign walk      = walk_reg;
  assign flash     = flash_reg;
  assign dont_walk = dont_walk_reg;
  assign waiting   = waiting_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed-vector bench for ped_crossing_ctrl; outputs are packed as
// {hold, walk, flash, dont_walk, waiting, fault} and checked 1 ns after each edge.
module tb_ped_crossing_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic red = 1'b0, amber = 1'b0, green = 1'b1;
  logic button = 1'b0;
  logic hold, walk, flash, dont_walk, waiting, fault;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] O_IDLE    = 6'b000100;
  localparam logic [5:0] O_WAIT    = 6'b000110;
  localparam logic [5:0] O_WALK    = 6'b110000;
  localparam logic [5:0] O_FLASH1  = 6'b101000;
  localparam logic [5:0] O_FLASH0  = 6'b100000;
  localparam logic [5:0] O_CLEAR   = 6'b100100;

  ped_crossing_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .red       (red),
    .amber     (amber),
    .green     (green),
    .button    (button),
    .hold      (hold),
    .walk      (walk),
    .flash     (flash),
    .dont_walk (dont_walk),
    .waiting   (waiting),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (hold,walk,flash,dont_walk,waiting,fault)", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [2:0] code);
    {red, amber, green} = code;
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    tick();
    check_val(tag, {hold, walk, flash, dont_walk, waiting, fault}, exp);
  endtask

  // One-cycle press; waiting must rise on the second edge after the press.
  task automatic press_and_wait(input string tag, input logic [5:0] idle_o, input logic [5:0] wait_o);
    button = 1'b1;
    step({tag, "_p0"}, idle_o);
    button = 1'b0;
    step({tag, "_p1"}, idle_o);
    step({tag, "_p2"}, wait_o);
  endtask

  // Remainder of a crossing after the first walk cycle has been checked.
  task automatic crossing_tail(input string tag);
    for (int i = 2; i <= 8; i++) step($sformatf("%s_walk%0d", tag, i), O_WALK);
    step({tag, "_fl1"}, O_FLASH1);
    step({tag, "_fl2"}, O_FLASH0);
    step({tag, "_fl3"}, O_FLASH1);
    step({tag, "_fl4"}, O_FLASH0);
    step({tag, "_clear"}, O_CLEAR);
    step({tag, "_idle"}, O_IDLE);
  endtask

  initial begin
    // 1. reset and normal lamp cycling without a press
    set_lamps(3'b001);
    for (int i = 0; i < 3; i++) step($sformatf("rst%0d", i), O_IDLE);
    rst_n = 1'b1;
    set_lamps(3'b001); step("cyc_g", O_IDLE);
    set_lamps(3'b010); step("cyc_a", O_IDLE);
    set_lamps(3'b100); step("cyc_r", O_IDLE);
    set_lamps(3'b100); step("cyc_r2", O_IDLE);
    set_lamps(3'b110); step("cyc_ra", O_IDLE);
    set_lamps(3'b001); step("cyc_g2", O_IDLE);

    // 2. normal crossing
    press_and_wait("n", O_IDLE, O_WAIT);
    set_lamps(3'b010); step("n_amber", O_WAIT);
    set_lamps(3'b100); step("n_walk1", O_WALK);
    crossing_tail("n");

    // 3. press during WALK ignored, press landing in CLEAR latched
    set_lamps(3'b001);
    press_and_wait("m", O_IDLE, O_WAIT);
    set_lamps(3'b100); step("m_walk1", O_WALK);
    button = 1'b1;
    step("m_walk2", O_WALK);
    button = 1'b0;
    for (int i = 3; i <= 8; i++) step($sformatf("m_walk%0d", i), O_WALK);
    step("m_fl1", O_FLASH1);
    step("m_fl2", O_FLASH0);
    step("m_fl3", O_FLASH1);
    button = 1'b1;
    step("m_fl4", O_FLASH0);
    button = 1'b0;
    step("m_clear", O_CLEAR);
    step("m_idle_req", O_WAIT);
    step("m2_walk1", O_WALK);
    crossing_tail("m2");

    // 6. asynchronous reset mid-FLASH
    set_lamps(3'b001);
    press_and_wait("r", O_IDLE, O_WAIT);
    set_lamps(3'b100); step("r_walk1", O_WALK);
    for (int i = 2; i <= 8; i++) step($sformatf("r_walk%0d", i), O_WALK);
    step("r_fl1", O_FLASH1);
    step("r_fl2", O_FLASH0);
    #2 rst_n = 1'b0;
    #1 check_val("r_async", {hold, walk, flash, dont_walk, waiting, fault}, O_IDLE);
    step("r_held", O_IDLE);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("r_post%0d", i), O_IDLE);

    // 4. hold violation on walk cycle 3
    set_lamps(3'b001);
    press_and_wait("v", O_IDLE, O_WAIT);
    set_lamps(3'b100); step("v_walk1", O_WALK);
    step("v_walk2", O_WALK);
    step("v_walk3", O_WALK);
    set_lamps(3'b001);
    step("v_clear", 6'b100101);
    step("v_idle", 6'b000101);
    step("v_idle2", 6'b000101);

    // 5. illegal lamp code in IDLE with a pending request
    rst_n = 1'b0;
    step("i_rst", O_IDLE);
    rst_n = 1'b1;
    set_lamps(3'b001);
    press_and_wait("i", O_IDLE, O_WAIT);
    set_lamps(3'b110); step("i_redamber", O_WAIT);
    set_lamps(3'b111); step("i_illegal", 6'b000111);
    step("i_illegal2", 6'b000111);
    set_lamps(3'b100); step("i_walk1", 6'b110001);
    step("i_walk2", 6'b110001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
Downstream companion to the traffic-light FSM. It consumes the FSM's red/amber/green lamp outputs and drives a pedestrian crossing: walk, dont_walk, flashing and waiting lamps. It latches button requests and starts the walk phase only while the traffic lights show red alone. While pedestrians cross, it asserts a hold output back to the traffic FSM. It also flags illegal lamp combinations as a sticky fault.

Parameters:
WALK_CYCLES, 8, number of clock cycles the steady walk lamp is on (min 1)
FLASH_CYCLES, 4, number of cycles in the flashing phase (min 1)
CNT_W, 4, phase counter width; must hold max(WALK_CYCLES, FLASH_CYCLES)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
red  input  1  traffic red lamp from traffic FSM
amber  input  1  traffic amber lamp from traffic FSM
green  input  1  traffic green lamp from traffic FSM
button  input  1  pedestrian push button, asynchronous level
hold  output  1  request to the traffic FSM to stay on red
walk  output  1  steady walk lamp
flash  output  1  flashing walk lamp
dont_walk  output  1  don't-walk lamp
waiting  output  1  request-pending lamp
fault  output  1  sticky illegal-lamp / hold-violation flag

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: hold=0, walk=0, flash=0, dont_walk=1, waiting=0, fault=0; state=IDLE; counter=0; synchroniser flops=0.
- All outputs are registered (Moore); there are no combinational paths from inputs to outputs.
- Legal lamp codes {red,amber,green}: 100, 110, 001, 010. All other codes are illegal.
- Button path:
  - 2-FF synchroniser, then rising-edge detect on the synchronised level.
  - With button high before edge k: the request latch sets at edge k+2, so waiting=1 from edge k+2.
  - A held button produces one request only.
- States: IDLE, WALK, FLASH, CLEAR. Encodings live in the package.
- IDLE:
  - dont_walk=1.
  - If req=1 and the lamps sample 100 at an edge -> WALK at that edge. On entry: walk=1, hold=1, waiting=0, req cleared, counter loads WALK_CYCLES-1.
  - Lamps 110 do not start a walk.
- WALK:
  - walk=1, dont_walk=0, hold=1.
  - Counter decrements each edge. At counter 0 -> FLASH and the counter loads FLASH_CYCLES-1.
  - walk is high for exactly WALK_CYCLES cycles.
- FLASH:
  - walk=0, dont_walk=0, hold=1.
  - flash is 1 on the first FLASH cycle and toggles every cycle (1,0,1,0,...).
  - At counter 0 -> CLEAR.
- CLEAR:
  - Lasts exactly one cycle: dont_walk=1, hold=1, flash=0.
  - Then -> IDLE with hold=0.
- Requests:
  - Button edges in WALK and FLASH are ignored.
  - Edges in CLEAR or IDLE latch a request for the next cycle of operation.
- Violation:
  - In WALK or FLASH, if the lamps sample anything other than 100 -> fault=1 and CLEAR at the next edge, skipping remaining walk/flash cycles.
- Illegal code in any state -> fault=1. In IDLE, no walk starts while the code is illegal.
- fault clears only on reset.
- Simultaneous events: a violation takes priority over counter expiry. A request edge coincident with WALK entry is absorbed, not re-latched.
- Reset mid-operation: all outputs and state return to their reset values immediately, asynchronously. Any pending request is discarded.

Decomposition:
- Package ped_pkg:
  - state enum/localparams: IDLE=2'd0, WALK=2'd1, FLASH=2'd2, CLEAR=2'd3.
  - lamp code constants: L_RED=3'b100, L_RED_AMBER=3'b110, L_GREEN=3'b001, L_AMBER=3'b010.
- Sub-module btn_sync:
  - 2-FF synchroniser plus rising-edge pulse.
  - Ports clk, rst_n, async_in, pulse.
  - Instantiated once in ped_crossing_ctrl.

Test Plan:
1. Reset: rst_n=0 for 3 cycles -> hold=0, walk=0, flash=0, dont_walk=1, waiting=0, fault=0. Release, lamps cycle normally with no press -> walk never asserts.
2. Normal crossing (defaults):
   - Press button for 1 cycle while lamps=001 -> waiting=1 two edges later, walk=0.
   - Lamps move to 010 then 100 -> walk=1 and hold=1 at the first edge sampling 100, waiting=0.
   - walk=1 for 8 cycles, then flash 1,0,1,0.
   - Then 1 CLEAR cycle (dont_walk=1, hold=1), then hold=0.
3. Request masking: press again during WALK -> waiting stays 0 through the end of CLEAR. Press during CLEAR -> waiting=1 and a second crossing starts on the next 100.
4. Hold violation: lamps change to 001 on WALK cycle 3 -> next edge dont_walk=1, walk=0, fault=1, hold=1 for that one cycle, then IDLE with hold=0.
5. Illegal code: lamps=111 in IDLE with a request pending -> fault=1, no walk. Then lamps=100 -> walk starts and fault stays 1.
6. Async reset mid-FLASH: drop rst_n between clock edges -> outputs return to reset values without a clock edge. After release with lamps=100 and no press -> no walk.
